// File: rtl/bound_flasher_pkg.sv
// rtl/bound_flasher_pkg.sv - state encodings, lamp bounds and step helpers for bound_flasher
package bound_flasher_pkg;

  // Sequence phases; code 7 is unused and recovers to INIT.
  typedef enum logic [2:0] {
    INIT     = 3'd0,
    UP_0_15  = 3'd1,
    DOW_15_5 = 3'd2,
    UP_5_10  = 3'd3,
    DOW_10_0 = 3'd4,
    UP_0_5   = 3'd5,
    DOW_5_0  = 3'd6
  } state_e;

  localparam int unsigned LAMP_W = 16;

  // Thermometer bounds at which the sequence turns around.
  localparam logic [LAMP_W-1:0] LAMP_FULL = 16'hFFFF;
  localparam logic [LAMP_W-1:0] LAMP_MID  = 16'h07FF;
  localparam logic [LAMP_W-1:0] LAMP_LOW  = 16'h003F;
  localparam logic [LAMP_W-1:0] LAMP_KICK = 16'h001F;
  localparam logic [LAMP_W-1:0] LAMP_OFF  = 16'h0000;

  // One more lamp on at the top of the thermometer.
  function automatic logic [LAMP_W-1:0] lamp_up(input logic [LAMP_W-1:0] l);
    return {l[LAMP_W-2:0], 1'b1};
  endfunction

  // One lamp off at the top of the thermometer.
  function automatic logic [LAMP_W-1:0] lamp_down(input logic [LAMP_W-1:0] l);
    return l >> 1;
  endfunction

endpackage

// File: rtl/bound_flasher.sv
// rtl/bound_flasher.sv - sixteen-lamp bound flasher with kickback on flick
module bound_flasher
  import bound_flasher_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flick,
  output logic [LAMP_W-1:0] lamp
);

  state_e            state;
  state_e            state_d;
  logic [LAMP_W-1:0] lamp_q;
  logic [LAMP_W-1:0] lamp_d;

  assign lamp = lamp_q;

  // Step the lamp and pick the next phase; bound and kickback tests look at the new lamp value.
  always_comb begin
    state_d = state;
    lamp_d  = lamp_q;
    unique case (state)
      INIT: begin
        lamp_d = LAMP_OFF;
        if (flick) begin
          lamp_d  = lamp_up(LAMP_OFF);
          state_d = UP_0_15;
        end
      end
      UP_0_15: begin
        lamp_d = lamp_up(lamp_q);
        if (lamp_d == LAMP_FULL) state_d = DOW_15_5;
      end
      DOW_15_5: begin
        lamp_d = lamp_down(lamp_q);
        if (lamp_d == LAMP_KICK) state_d = flick ? UP_0_15 : UP_5_10;
      end
      UP_5_10: begin
        lamp_d = lamp_up(lamp_q);
        if (lamp_d == LAMP_MID) state_d = DOW_10_0;
      end
      DOW_10_0: begin
        lamp_d = lamp_down(lamp_q);
        if (lamp_d == LAMP_KICK && flick) state_d = UP_5_10;
        else if (lamp_d == LAMP_OFF)      state_d = flick ? UP_5_10 : UP_0_5;
      end
      UP_0_5: begin
        lamp_d = lamp_up(lamp_q);
        if (lamp_d == LAMP_LOW) state_d = DOW_5_0;
      end
      DOW_5_0: begin
        lamp_d = lamp_down(lamp_q);
        if (lamp_d == LAMP_OFF) state_d = INIT;
      end
      default: begin
        state_d = INIT;
        lamp_d  = LAMP_OFF;
      end
    endcase
  end

  // Phase and lamp registers; reset clears both without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= INIT;
      lamp_q <= LAMP_OFF;
    end else begin
      state  <= state_d;
      lamp_q <= lamp_d;
    end
  end

endmodule

// File: tb/tb_bound_flasher.sv
// tb/tb_bound_flasher.sv - directed scoreboard bench for bound_flasher
module tb_bound_flasher;

  typedef struct {
    bit          f;
    logic [15:0] lamp;
    logic [2:0]  st;
  } entry_t;

  logic        clk;
  logic        rst_n;
  logic        flick;
  logic [15:0] lamp;

  entry_t plan[$];
  entry_t sb[$];
  int     n_assert;
  int     n_fail;

  bound_flasher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flick (flick),
    .lamp  (lamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] thermo(input int n);
    logic [16:0] t;
    t = (17'd1 << n) - 17'd1;
    return t[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic add(input bit f, input logic [15:0] l, input int st);
    entry_t e;
    e.f    = f;
    e.lamp = l;
    e.st   = st[2:0];
    plan.push_back(e);
  endtask

  // Ramp lamp count a..b; the state after the final edge is nxt.
  task automatic seg(input int a, input int b, input int cur, input int nxt,
                     input bit f, input bit rnd);
    int n;
    bit fv;
    n = a;
    while (1) begin
      if (rnd) begin
        if ((cur == 2 || cur == 4) && (n == 5 || n == 0)) fv = 1'b0;
        else fv = 1'($urandom_range(0, 1));
      end else begin
        fv = f;
      end
      add(fv, thermo(n), (n == b) ? nxt : cur);
      if (n == b) break;
      n = n + ((b > a) ? 1 : -1);
    end
  endtask

  task automatic normal_run(input bit rnd);
    add(1'b1, 16'h0001, 1);
    seg(2, 16, 1, 2, 1'b0, rnd);
    seg(15, 5, 2, 3, 1'b0, rnd);
    seg(6, 11, 3, 4, 1'b0, rnd);
    seg(10, 0, 4, 5, 1'b0, rnd);
    seg(1, 6, 5, 6, 1'b0, rnd);
    seg(5, 0, 6, 0, 1'b0, rnd);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) add(1'b0, 16'h0000, 0);
  endtask

  // Drive up to max planned edges; each expectation enters the scoreboard as its stimulus is driven.
  task automatic run_plan(input int max, input string tag);
    entry_t e;
    entry_t x;
    int     i;
    i = 0;
    while (plan.size() > 0 && i < max) begin
      e = plan.pop_front();
      sb.push_back(e);
      flick = e.f;
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk({tag, "_lamp"}, {16'h0, lamp}, {16'h0, x.lamp});
      chk({tag, "_state"}, {29'h0, dut.state}, {29'h0, x.st});
      i++;
    end
    plan.delete();
    flick = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_lamp"}, {16'h0, lamp}, 32'h0);
    chk({tag, "_rst_state"}, {29'h0, dut.state}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int kpts[6];
    n_assert = 0;
    n_fail   = 0;
    flick    = 1'b0;
    rst_n    = 1'b0;
    #3;
    chk("por_lamp", {16'h0, lamp}, 32'h0);
    chk("por_state", {29'h0, dut.state}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    idle(2);
    run_plan(1000, "idle0");

    // Partial run abandoned by a mid-cycle reset, then a full normal run.
    normal_run(1'b0);
    run_plan(10, "partial");
    async_reset("mid");
    idle(2);
    normal_run(1'b0);
    idle(4);
    run_plan(1000, "normal");

    // flick held high: oscillates between 0x001F and 0xFFFF.
    add(1'b1, 16'h0001, 1);
    seg(2, 16, 1, 2, 1'b1, 1'b0);
    seg(15, 5, 2, 1, 1'b1, 1'b0);
    seg(6, 16, 1, 2, 1'b1, 1'b0);
    seg(15, 5, 2, 1, 1'b1, 1'b0);
    seg(6, 16, 1, 2, 1'b1, 1'b0);
    run_plan(1000, "held");
    async_reset("held");

    // Kickbacks in DOW_10_0 at 0x001F and at 0x0000.
    add(1'b1, 16'h0001, 1);
    seg(2, 16, 1, 2, 1'b0, 1'b0);
    seg(15, 5, 2, 3, 1'b0, 1'b0);
    seg(6, 11, 3, 4, 1'b0, 1'b0);
    seg(10, 5, 4, 3, 1'b1, 1'b0);
    seg(6, 11, 3, 4, 1'b0, 1'b0);
    seg(10, 6, 4, 4, 1'b0, 1'b0);
    add(1'b0, 16'h001F, 4);
    seg(4, 0, 4, 3, 1'b1, 1'b0);
    seg(1, 11, 3, 4, 1'b0, 1'b0);
    seg(10, 0, 4, 5, 1'b0, 1'b0);
    seg(1, 6, 5, 6, 1'b0, 1'b0);
    seg(5, 0, 6, 0, 1'b0, 1'b0);
    idle(2);
    run_plan(1000, "kick");

    // Asynchronous reset inside each of states 1..6.
    kpts = '{3, 18, 29, 36, 46, 52};
    foreach (kpts[k]) begin
      normal_run(1'b0);
      run_plan(kpts[k], $sformatf("pre%0d", k + 1));
      async_reset($sformatf("st%0d", k + 1));
      idle(3);
      run_plan(1000, $sformatf("post%0d", k + 1));
    end

    // flick toggling away from kickback points must not disturb the sequence.
    normal_run(1'b1);
    idle(3);
    run_plan(1000, "toggle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
